// File: rtl/dff_async.sv
// Cascaded D register with asynchronous active-low reset.
// d_out is the last of STAGES stages, so the latency is STAGES clock edges.
module dff_async #(
  parameter int unsigned      WIDTH       = 1,
  parameter int unsigned      STAGES      = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out
);

  if (WIDTH < 1 || STAGES < 1) begin : g_param_check
    $error("dff_async: WIDTH and STAGES must both be at least 1");
  end

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  always_comb begin
    stage_d[0] = d_in;
    for (int unsigned i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Reset wins over clk: any in-flight data is discarded while reset_n is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage_q[i] <= RESET_VALUE;
      end
    end else begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign d_out = stage_q[STAGES-1];

endmodule

// File: tb/tb_dff_async.sv
// Scoreboard bench for dff_async: a 1-bit single-stage instance and an
// 8-bit three-stage instance with a non-zero reset value.
module tb_dff_async;

  typedef struct {
    string      name;
    bit         dut_b;
    logic [7:0] exp;
  } chk_t;

  logic       clk;
  logic       rst_n_a, rst_n_b;
  logic       d_in_a, d_out_a;
  logic [7:0] d_in_b, d_out_b;

  chk_t edge_q[$];
  chk_t async_q[$];
  event mid_ev;

  int checks   = 0;
  int failures = 0;

  dff_async u_dut_a (
    .clk     (clk),
    .reset_n (rst_n_a),
    .d_in    (d_in_a),
    .d_out   (d_out_a)
  );

  dff_async #(
    .WIDTH       (8),
    .STAGES      (3),
    .RESET_VALUE (8'hA5)
  ) u_dut_b (
    .clk     (clk),
    .reset_n (rst_n_b),
    .d_in    (d_in_b),
    .d_out   (d_out_b)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: sim time %0t exceeded limit 100000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic compare(input chk_t c);
    logic [7:0] act;
    act = c.dut_b ? d_out_b : {7'b0, d_out_a};
    checks++;
    if (act !== c.exp) begin
      failures++;
      $display("FAIL %s @%0t: d_out=%h expected=%h", c.name, $time, act, c.exp);
    end
  endtask

  // Expected value for the next rising edge.
  task automatic push_e(input string name, input bit b, input logic [7:0] exp);
    chk_t c;
    c.name = name; c.dut_b = b; c.exp = exp;
    edge_q.push_back(c);
  endtask

  // Expected value for an off-edge event (reset assertion or mid-cycle poke).
  task automatic push_a(input string name, input bit b, input logic [7:0] exp);
    chk_t c;
    c.name = name; c.dut_b = b; c.exp = exp;
    async_q.push_back(c);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      while (edge_q.size() > 0) compare(edge_q.pop_front());
    end
  end

  initial begin
    forever begin
      @(negedge rst_n_a or negedge rst_n_b or mid_ev);
      #1;
      while (async_q.size() > 0) compare(async_q.pop_front());
    end
  end

  logic       pat_a [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [7:0] in_b  [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  logic [7:0] exp_b [5] = '{8'hA5, 8'hA5, 8'h11, 8'h22, 8'h33};

  initial begin
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    d_in_a  = 1'b0;
    d_in_b  = 8'hFF;

    // Power-up reset with random data on d_in
    push_e("pwr_reset", 0, 8'h00);
    repeat (9) begin
      @(negedge clk);
      d_in_a = 1'($urandom);
      push_e("pwr_reset", 0, 8'h00);
    end

    // Release and follow d_in
    @(negedge clk);
    rst_n_a = 1'b1;
    d_in_a  = 1'b0;
    push_e("release_idle", 0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      d_in_a = pat_a[i];
      push_e("follow", 0, {7'b0, pat_a[i]});
    end
    @(negedge clk);
    d_in_a = 1'b1;
    push_e("load_one", 0, 8'h01);

    // Asynchronous assertion between rising edges
    @(negedge clk);
    push_a("async_assert", 0, 8'h00);
    rst_n_a = 1'b0;
    push_e("rst_dominant", 0, 8'h00);
    repeat (9) begin
      @(negedge clk);
      d_in_a = 1'b1;
      push_e("rst_dominant", 0, 8'h00);
    end
    @(negedge clk);
    rst_n_a = 1'b1;
    push_e("release_first", 0, 8'h01);

    // Hold, then a mid-cycle input change
    repeat (5) begin
      @(negedge clk);
      push_e("hold", 0, 8'h01);
    end
    @(posedge clk);
    #5;
    d_in_a = 1'b0;
    push_a("hold_midcycle", 0, 8'h01);
    -> mid_ev;
    @(negedge clk);
    push_e("after_change", 0, 8'h00);

    // Three-stage instance
    @(negedge clk);
    push_a("b_reset", 1, 8'hA5);
    -> mid_ev;
    push_e("b_reset_edge", 1, 8'hA5);
    @(negedge clk);
    rst_n_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      d_in_b = in_b[i];
      push_e("b_pipe", 1, exp_b[i]);
    end
    @(posedge clk);
    #5;
    push_a("b_mid_reset", 1, 8'hA5);
    rst_n_b = 1'b0;
    @(negedge clk);
    d_in_b = 8'h66;
    push_e("b_rst_hold", 1, 8'hA5);
    @(negedge clk);
    rst_n_b = 1'b1;
    d_in_b  = 8'h77;
    push_e("b_refill", 1, 8'hA5);
    @(negedge clk);
    d_in_b = 8'h88;
    push_e("b_refill", 1, 8'hA5);
    @(negedge clk);
    d_in_b = 8'h99;
    push_e("b_refill", 1, 8'h77);
    @(negedge clk);
    d_in_b = 8'h00;
    push_e("b_refill", 1, 8'h88);

    repeat (3) @(negedge clk);
    checks++;
    if (edge_q.size() != 0 || async_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: pending=%0d expected=0",
               edge_q.size() + async_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
